// File: rtl/start_seq_ctrl_if.sv
// Handshake bundle for start_seq_ctrl: the request side drives start/abort/run_len,
// the controller returns run status and counters.
interface start_seq_ctrl_if #(
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic [CW-1:0] run_len;
  logic          busy;
  logic          done;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] start_count;
  logic          overflow;

  modport master (
    output start, abort, run_len,
    input  busy, done, run_cnt, start_count, overflow
  );

  modport slave (
    input  start, abort, run_len,
    output busy, done, run_cnt, start_count, overflow
  );
endinterface

// File: rtl/start_seq_ctrl.sv
// Start-sequenced run controller: a rising edge on start launches a run of
// run_len cycles, one further request may be queued while running, abort
// cancels everything, and every rise is counted (saturating).
module start_seq_ctrl #(
  parameter int CW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  start_seq_ctrl_if.slave sif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_start_d;
  logic          r_pending;
  logic          r_overflow;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_run_cnt;
  logic [CW-1:0] r_start_count;

  logic          w_rise;
  logic          w_last;
  logic          w_enter_run;
  logic [CW-1:0] w_len_sel;

  assign w_rise      = sif.start & ~r_start_d;
  assign w_last      = (r_run_cnt == (r_len - CW'(1)));
  // A zero length still runs for one cycle so every accepted rise yields a done.
  assign w_len_sel   = (sif.run_len == '0) ? CW'(1) : sif.run_len;
  assign w_enter_run = (w_next == S_RUN) && (r_state != S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state selection; abort outranks any rise or queued request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise && !sif.abort) w_next = S_RUN;
      end
      S_RUN: begin
        if (sif.abort)   w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (sif.abort)                  w_next = S_IDLE;
        else if (r_pending || w_rise)   w_next = S_RUN;
        else                            w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Edge detector, counters, run length latch and the one-deep request queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_d     <= 1'b0;
      r_start_count <= '0;
      r_len         <= '0;
      r_run_cnt     <= '0;
      r_pending     <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_start_d <= sif.start;

      if (w_rise && (r_start_count != '1))
        r_start_count <= r_start_count + CW'(1);

      if (w_enter_run) begin
        r_len     <= w_len_sel;
        r_run_cnt <= '0;
        r_pending <= 1'b0;
      end else if ((r_state == S_RUN) && (w_next == S_RUN)) begin
        r_run_cnt <= r_run_cnt + CW'(1);
      end else begin
        r_run_cnt <= '0;
      end

      // A rise while a request is already queued is lost and flagged.
      if ((r_state == S_RUN) && !sif.abort && w_rise) begin
        if (r_pending) r_overflow <= 1'b1;
        else           r_pending  <= 1'b1;
      end

      if (sif.abort) r_pending <= 1'b0;
    end
  end

  assign sif.busy        = (r_state == S_RUN);
  assign sif.done        = (r_state == S_DONE);
  assign sif.run_cnt     = r_run_cnt;
  assign sif.start_count = r_start_count;
  assign sif.overflow    = r_overflow;

endmodule

// File: tb/tb_start_seq_ctrl.sv
// Directed bench for start_seq_ctrl: cycle-by-cycle vector table plus
// hand-written saturation/reset and periodic-start sequences.
module tb_start_seq_ctrl;

  localparam int CW = 8;

  logic clk;
  logic rst_n;

  start_seq_ctrl_if #(.CW(CW)) sif ();

  start_seq_ctrl #(.CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [CW-1:0] len;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    logic [CW-1:0] sc;
    logic          ov;
  } vec_t;

  vec_t tbl[$];
  int   n_pass;
  int   n_total;

  task automatic add(input int r, input int s, input int a, input int l,
                     input int b, input int d, input int c, input int sc,
                     input int ov);
    vec_t v;
    v.rst_n = r[0];  v.start = s[0]; v.abort = a[0]; v.len = l[CW-1:0];
    v.busy  = b[0];  v.done  = d[0]; v.cnt   = c[CW-1:0];
    v.sc    = sc[CW-1:0]; v.ov = ov[0];
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pack_out();
    return {13'd0, sif.busy, sif.done, sif.run_cnt, sif.start_count, sif.overflow};
  endfunction

  initial begin
    longint last_t;
    int     ndone;
    int     ovseen;
    vec_t   v;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.run_len = '0;

    //  rst s a len | busy done cnt sc ov
    // reset, basic 3-cycle run (run_len changed mid-run), zero length
    add(0,0,0,3, 0,0,0,0,0);
    add(0,0,0,3, 0,0,0,0,0);
    add(1,0,0,3, 0,0,0,0,0);
    add(1,1,0,3, 1,0,0,1,0);
    add(1,0,0,7, 1,0,1,1,0);
    add(1,0,0,7, 1,0,2,1,0);
    add(1,0,0,7, 0,1,0,1,0);
    add(1,0,0,0, 0,0,0,1,0);
    add(1,1,0,0, 1,0,0,2,0);
    add(1,0,0,0, 0,1,0,2,0);
    add(1,0,0,0, 0,0,0,2,0);
    // queue and overflow with run_len=5
    add(0,0,0,5, 0,0,0,0,0);
    add(1,1,0,5, 1,0,0,1,0);
    add(1,0,0,5, 1,0,1,1,0);
    add(1,1,0,5, 1,0,2,2,0);
    add(1,0,0,5, 1,0,3,2,0);
    add(1,1,0,5, 1,0,4,3,1);
    add(1,0,0,5, 0,1,0,3,1);
    add(1,0,0,5, 1,0,0,3,1);
    add(1,0,0,5, 1,0,1,3,1);
    add(1,0,0,5, 1,0,2,3,1);
    add(1,0,0,5, 1,0,3,3,1);
    add(1,0,0,5, 1,0,4,3,1);
    add(1,0,0,5, 0,1,0,3,1);
    add(1,0,0,5, 0,0,0,3,1);
    // abort at run_cnt=2 with a queued request, then abort+rise in IDLE
    add(0,0,0,6, 0,0,0,0,0);
    add(1,1,0,6, 1,0,0,1,0);
    add(1,0,0,6, 1,0,1,1,0);
    add(1,1,0,6, 1,0,2,2,0);
    add(1,0,1,6, 0,0,0,2,0);
    add(1,0,0,6, 0,0,0,2,0);
    add(1,0,0,6, 0,0,0,2,0);
    add(1,0,0,6, 0,0,0,2,0);
    add(1,1,1,6, 0,0,0,3,0);
    add(1,0,0,6, 0,0,0,3,0);
    // run_len=1: abort in DONE suppresses a rise; rise in DONE chains a run
    add(1,1,0,1, 1,0,0,4,0);
    add(1,0,0,1, 0,1,0,4,0);
    add(1,1,1,1, 0,0,0,5,0);
    add(1,0,0,1, 0,0,0,5,0);
    add(1,1,0,1, 1,0,0,6,0);
    add(1,0,0,1, 0,1,0,6,0);
    add(1,1,0,1, 1,0,0,7,0);
    add(1,0,0,1, 0,1,0,7,0);
    add(1,0,0,1, 0,0,0,7,0);
    // reset mid-run: no done pulse afterwards
    add(1,1,0,4, 1,0,0,8,0);
    add(1,0,0,4, 1,0,1,8,0);
    add(0,0,0,4, 0,0,0,0,0);
    add(1,0,0,4, 0,0,0,0,0);
    // start held high across reset release counts once
    add(0,1,0,4, 0,0,0,0,0);
    add(1,1,0,4, 1,0,0,1,0);
    add(1,1,0,4, 1,0,1,1,0);
    add(1,0,0,4, 1,0,2,1,0);
    add(1,0,0,4, 1,0,3,1,0);
    add(1,0,0,4, 0,1,0,1,0);
    add(1,0,0,4, 0,0,0,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst_n = v.rst_n;
      sif.start = v.start;
      sif.abort = v.abort;
      sif.run_len = v.len;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d{busy,done,cnt,sc,ov}", i), pack_out(),
          {13'd0, v.busy, v.done, v.cnt, v.sc, v.ov});
    end

    // saturation: 260 rises with abort held so no runs start
    @(negedge clk);
    rst_n = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      if (i == 254) chk("start_count_at_255", 32'(sif.start_count), 32'd255);
      if (i == 0)   chk("abort_blocks_run", 32'(sif.busy), 32'd0);
    end
    chk("start_count_saturated", 32'(sif.start_count), 32'd255);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_clears_outputs", pack_out(), 32'd0);

    // periodic start at 40 time units, run_len=2
    @(negedge clk);
    rst_n = 1'b1;
    sif.abort = 1'b0;
    sif.run_len = 8'd2;
    ndone = 0;
    ovseen = 0;
    last_t = -1;
    fork
      begin
        repeat (8) begin
          sif.start = 1'b1;
          #20;
          sif.start = 1'b0;
          #20;
        end
      end
      begin
        for (int k = 0; k < 36; k++) begin
          @(posedge clk);
          #1;
          if (sif.done) begin
            ndone++;
            if (last_t >= 0) chk("done_period", 32'($time - last_t), 32'd40);
            last_t = $time;
          end
          if (sif.overflow) ovseen = 1;
        end
      end
    join
    chk("periodic_done_count", 32'(ndone), 32'd8);
    chk("periodic_overflow", 32'(ovseen), 32'd0);
    chk("periodic_start_count", 32'(sif.start_count), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
